// File: rtl/minsoc_clk_pkg.sv
// Shared definitions for the divided-clock monitor: FSM state encoding and
// the timeout multiplier applied to the expected divide ratio.
package minsoc_clk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAULT   = 2'd3
    } mon_state_t;

    // A divided period longer than TIMEOUT_MULT * DIVISOR source cycles
    // means the divided clock has stopped.
    localparam int TIMEOUT_MULT = 4;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level, plus a history flop that
// turns a synchronized rising transition into a one-cycle pulse.
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic edge_o
);

    logic s1;
    logic s2;
    logic s3;

    // Synchronizer chain (s1, s2) followed by the history flop s3
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_o = s2 & ~s3;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures the period of a divided clock in source-clock cycles, tracks
// lock/fault status and produces a clean active-low reset for the divided
// domain once the ratio has been stable long enough.
//
// Outputs period_o, period_valid_o, lock_o, fault_o and rst_out_n_o are all
// registered. state_o exposes the FSM state for debug and checkers.
// clear_i wins over every other transition: state goes to IDLE and the
// period, good-period and delay counters are cleared; no strobe is issued
// on a clear cycle.
module clk_div_monitor
    import minsoc_clk_pkg::*;
#(
    parameter int DIVISOR    = 2,
    parameter int TOLERANCE  = 1,
    parameter int LOCK_COUNT = 16,
    parameter int RST_DELAY  = 4,
    parameter int MEAS_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  div_clk_i,
    input  logic                  clear_i,
    output logic [MEAS_WIDTH-1:0] period_o,
    output logic                  period_valid_o,
    output logic                  lock_o,
    output logic                  fault_o,
    output logic                  rst_out_n_o,
    output logic [1:0]            state_o
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int DW = (RST_DELAY > 1) ? $clog2(RST_DELAY) : 1;

    localparam logic [MEAS_WIDTH-1:0] TIMEOUT_CNT = MEAS_WIDTH'(TIMEOUT_MULT * DIVISOR);
    localparam logic [MEAS_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [MEAS_WIDTH-1:0] LO_LIM      =
        MEAS_WIDTH'((DIVISOR > TOLERANCE) ? (DIVISOR - TOLERANCE) : 0);
    localparam logic [MEAS_WIDTH-1:0] HI_LIM      = MEAS_WIDTH'(DIVISOR + TOLERANCE);
    localparam logic [GW-1:0]         GOOD_LAST   = GW'(LOCK_COUNT - 1);
    // RST_DELAY is expected to be at least 1.
    localparam logic [DW-1:0]         DLY_LAST    = DW'(RST_DELAY - 1);

    mon_state_t            state;
    logic [MEAS_WIDTH-1:0] cnt;
    logic [GW-1:0]         good_cnt;
    logic [DW-1:0]         dly_cnt;
    logic                  edge_det;
    logic                  period_good;
    logic                  timeout;

    sync_edge_det u_sync_edge_det (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .async_i (div_clk_i),
        .edge_o  (edge_det)
    );

    // cnt holds the cycles since the last edge, so on an edge it is the period.
    assign period_good = (cnt >= LO_LIM) && (cnt <= HI_LIM);
    // An edge in the timeout cycle wins, so timeout is masked by edge_det.
    assign timeout     = ~edge_det && (cnt == TIMEOUT_CNT);
    assign state_o     = state;

    // Period counter and period report; edges seen in IDLE are discarded
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt            <= '0;
            period_o       <= '0;
            period_valid_o <= 1'b0;
        end else begin
            period_valid_o <= 1'b0;
            if (clear_i) begin
                cnt <= '0;
            end else if (edge_det) begin
                cnt <= MEAS_WIDTH'(1);
                if (state != ST_IDLE) begin
                    period_o       <= cnt;
                    period_valid_o <= 1'b1;
                end
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Lock/fault FSM with registered status outputs and reset-release delay
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state       <= ST_IDLE;
            good_cnt    <= '0;
            dly_cnt     <= '0;
            lock_o      <= 1'b0;
            fault_o     <= 1'b0;
            rst_out_n_o <= 1'b0;
        end else if (clear_i) begin
            state       <= ST_IDLE;
            good_cnt    <= '0;
            dly_cnt     <= '0;
            lock_o      <= 1'b0;
            fault_o     <= 1'b0;
            rst_out_n_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (edge_det) begin
                        state    <= ST_ACQUIRE;
                        good_cnt <= '0;
                    end
                end
                ST_ACQUIRE: begin
                    if (edge_det) begin
                        if (period_good) begin
                            if (good_cnt == GOOD_LAST) begin
                                state    <= ST_LOCKED;
                                lock_o   <= 1'b1;
                                good_cnt <= '0;
                                dly_cnt  <= '0;
                            end else begin
                                good_cnt <= good_cnt + 1'b1;
                            end
                        end else begin
                            good_cnt <= '0;
                        end
                    end else if (timeout) begin
                        state    <= ST_IDLE;
                        good_cnt <= '0;
                    end
                end
                ST_LOCKED: begin
                    if ((edge_det && !period_good) || timeout) begin
                        state       <= ST_FAULT;
                        lock_o      <= 1'b0;
                        fault_o     <= 1'b1;
                        rst_out_n_o <= 1'b0;
                        dly_cnt     <= '0;
                    end else if (!rst_out_n_o) begin
                        if (dly_cnt == DLY_LAST) begin
                            rst_out_n_o <= 1'b1;
                        end else begin
                            dly_cnt <= dly_cnt + 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: two instances (DIVISOR=2/TOL=1 and
// DIVISOR=4/TOL=0) share one stimulus stream. A timestamp-based reference
// model predicts every output each cycle; reported periods go through an
// expected queue per instance.
module tb_clk_div_monitor;
    import minsoc_clk_pkg::*;

    localparam int LOCK_COUNT = 16;
    localparam int RST_DELAY  = 4;
    localparam int DIV_OF [2] = '{2, 4};
    localparam int TOL_OF [2] = '{1, 0};

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_n_i = 1'b0;
    logic div_clk_i = 1'b0;
    logic clear_i = 1'b0;

    always #5 clk_i = ~clk_i;

    logic [7:0] period_w [2];
    logic       valid_w  [2];
    logic       lock_w   [2];
    logic       fault_w  [2];
    logic       rsto_w   [2];
    logic [1:0] state_w  [2];

    clk_div_monitor #(.DIVISOR(2), .TOLERANCE(1), .LOCK_COUNT(16), .RST_DELAY(4), .MEAS_WIDTH(8)) u_dut0 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .div_clk_i(div_clk_i), .clear_i(clear_i),
        .period_o(period_w[0]), .period_valid_o(valid_w[0]), .lock_o(lock_w[0]),
        .fault_o(fault_w[0]), .rst_out_n_o(rsto_w[0]), .state_o(state_w[0])
    );

    clk_div_monitor #(.DIVISOR(4), .TOLERANCE(0), .LOCK_COUNT(16), .RST_DELAY(4), .MEAS_WIDTH(8)) u_dut1 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .div_clk_i(div_clk_i), .clear_i(clear_i),
        .period_o(period_w[1]), .period_valid_o(valid_w[1]), .lock_o(lock_w[1]),
        .fault_o(fault_w[1]), .rst_out_n_o(rsto_w[1]), .state_o(state_w[1])
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    // Edge times are absolute cycle numbers; a period is the distance
    // between two successive edge decisions.
    mon_state_t m_state  [2];
    int         m_last   [2];
    int         m_good   [2];
    int         m_lock_t [2];
    logic       e_valid  [2];
    logic       m_in_rst;
    logic       h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

    function automatic logic period_ok(input int u, input int per);
        return (per >= DIV_OF[u] - TOL_OF[u]) && (per <= DIV_OF[u] + TOL_OF[u]);
    endfunction

    task automatic model_step(input int u, input logic rn, input logic clr, input logic edg);
        int per;
        e_valid[u] = 1'b0;
        if (!rn || clr) begin
            m_state[u] = ST_IDLE;
            m_good[u]  = 0;
            return;
        end
        per = cyc - m_last[u];
        if (per > 255) per = 255;
        if (edg) begin
            if (m_state[u] != ST_IDLE) begin
                e_valid[u] = 1'b1;
                if (u == 0) exp_q0.push_back(8'(per));
                else        exp_q1.push_back(8'(per));
            end
            m_last[u] = cyc;
            case (m_state[u])
                ST_IDLE: begin
                    m_state[u] = ST_ACQUIRE;
                    m_good[u]  = 0;
                end
                ST_ACQUIRE: begin
                    if (period_ok(u, per)) begin
                        m_good[u]++;
                        if (m_good[u] == LOCK_COUNT) begin
                            m_state[u]  = ST_LOCKED;
                            m_lock_t[u] = cyc;
                        end
                    end else begin
                        m_good[u] = 0;
                    end
                end
                ST_LOCKED: if (!period_ok(u, per)) m_state[u] = ST_FAULT;
                default: ;
            endcase
        end else if (cyc - m_last[u] == 4 * DIV_OF[u]) begin
            if (m_state[u] == ST_ACQUIRE)     m_state[u] = ST_IDLE;
            else if (m_state[u] == ST_LOCKED) m_state[u] = ST_FAULT;
        end
    endtask

    task automatic compare(input int u);
        logic [7:0] ep;
        logic       e_rst;
        e_rst = (m_state[u] == ST_LOCKED) && (cyc - m_lock_t[u] >= RST_DELAY);
        check($sformatf("u%0d_state", u), 32'(state_w[u]), 32'(m_state[u]));
        check($sformatf("u%0d_lock", u), 32'(lock_w[u]), 32'(m_state[u] == ST_LOCKED));
        check($sformatf("u%0d_fault", u), 32'(fault_w[u]), 32'(m_state[u] == ST_FAULT));
        check($sformatf("u%0d_rst_out_n", u), 32'(rsto_w[u]), 32'(e_rst));
        check($sformatf("u%0d_valid", u), 32'(valid_w[u]), 32'(e_valid[u]));
        if (m_in_rst) check($sformatf("u%0d_period_rst", u), 32'(period_w[u]), 32'd0);
        if (valid_w[u] === 1'b1) begin
            if (u == 0) begin
                check("u0_period_q_nonempty", 32'(exp_q0.size() != 0), 32'd1);
                if (exp_q0.size() != 0) begin
                    ep = exp_q0.pop_front();
                    check("u0_period", 32'(period_w[0]), 32'(ep));
                end
            end else begin
                check("u1_period_q_nonempty", 32'(exp_q1.size() != 0), 32'd1);
                if (exp_q1.size() != 0) begin
                    ep = exp_q1.pop_front();
                    check("u1_period", 32'(period_w[1]), 32'(ep));
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input logic d, input logic clr, input logic rn);
        logic edg;
        div_clk_i = d;
        clear_i   = clr;
        rst_n_i   = rn;
        @(posedge clk_i);
        cyc++;
        edg = h2 & ~h3;
        m_in_rst = !rn;
        model_step(0, rn, clr, edg);
        model_step(1, rn, clr, edg);
        if (!rn) begin
            h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        end else begin
            h3 = h2; h2 = h1; h1 = d;
        end
        #1;
        compare(0);
        compare(1);
    endtask

    task automatic run_period(input int per, input int hi);
        for (int i = 0; i < per; i++) tick((i < hi) ? 1'b1 : 1'b0, 1'b0, 1'b1);
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) run_period(2, 1);
    endtask

    task automatic hold_low(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int r;
        int per;
        for (int u = 0; u < 2; u++) begin
            m_state[u] = ST_IDLE; m_last[u] = 0; m_good[u] = 0; m_lock_t[u] = 0; e_valid[u] = 1'b0;
        end
        m_in_rst = 1'b1;

        // Reset values
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        hold_low(2);

        // Clean divide-by-2 clock: lock after 1 + 16 edges, reset release 4 later
        clean(24);
        check("u0_locked_after_clean", 32'(lock_w[0]), 32'd1);
        check("u0_rst_out_after_clean", 32'(rsto_w[0]), 32'd1);

        // Divided clock stops: timeout fault, sticky
        hold_low(60);
        check("u0_fault_sticky", 32'(fault_w[0]), 32'd1);
        check("u0_lock_dropped", 32'(lock_w[0]), 32'd0);

        // Clear with a running clock, then relock
        tick(1'b0, 1'b1, 1'b1);
        check("u0_idle_after_clear", 32'(state_w[0]), 32'(ST_IDLE));
        clean(25);

        // One stretched period during acquisition restarts the good count
        tick(1'b0, 1'b1, 1'b1);
        k = $urandom_range(3, 10);
        clean(k);
        run_period(5, 1);
        clean(30);

        // Period of exactly 4*DIVISOR in ACQUIRE: edge wins over timeout
        tick(1'b0, 1'b1, 1'b1);
        clean(3);
        run_period(8, 1);
        clean(25);

        // Clear coincident with a bad edge while locked
        hold_low(4);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        check("u0_clear_vs_bad_edge_fault", 32'(fault_w[0]), 32'd0);
        check("u0_clear_vs_bad_edge_state", 32'(state_w[0]), 32'(ST_IDLE));
        clean(25);

        // One-cycle reset while locked, then full reacquire
        tick(1'b0, 1'b0, 1'b0);
        check("u0_rst_mid_lock", 32'(lock_w[0]), 32'd0);
        check("u0_rst_mid_rsto", 32'(rsto_w[0]), 32'd0);
        clean(25);

        // Alternating 4/5 periods: DIVISOR=4 TOL=0 instance never locks
        tick(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            run_period(4, 2);
            run_period(5, 2);
        end
        check("u1_never_locks", 32'(lock_w[1]), 32'd0);

        // Randomized mix of clean, jittered, stopped, cleared and reset periods
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55) clean(1);
            else if (r < 70) begin
                per = $urandom_range(2, 6);
                run_period(per, $urandom_range(1, per - 1));
            end else if (r < 85) begin
                per = $urandom_range(3, 5);
                run_period(per, $urandom_range(1, per - 1));
            end else if (r < 93) hold_low($urandom_range(4, 20));
            else if (r < 97) tick(1'b0, 1'b1, 1'b1);
            else tick(1'b0, 1'b0, 1'b0);
        end
        hold_low(4);

        check("u0_queue_drained", 32'(exp_q0.size()), 32'd0);
        check("u1_queue_drained", 32'(exp_q1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
